// File: rtl/aes_round_pkg.sv
// Shared types and byte-permutation helpers for the AES column round sequencer.
package aes_round_pkg;

    localparam int unsigned NUM_COLS  = 4;
    localparam int unsigned COL_IDX_W = $clog2(NUM_COLS);
    localparam int unsigned STATE_W   = 128;

    // Column-major state: [127:96] is column 0, row 0 in the top byte.
    typedef logic [STATE_W-1:0] state_t;
    // One column; element [3] is row 0.
    typedef logic [3:0][7:0] col_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic col_t get_col(input state_t s, input logic [COL_IDX_W-1:0] idx);
        col_t c;
        case (idx)
            2'd0:    c = s[127:96];
            2'd1:    c = s[95:64];
            2'd2:    c = s[63:32];
            default: c = s[31:0];
        endcase
        return c;
    endfunction

    function automatic state_t set_col(input state_t s, input logic [COL_IDX_W-1:0] idx,
                                       input col_t c);
        state_t t;
        t = s;
        case (idx)
            2'd0:    t[127:96] = c;
            2'd1:    t[95:64]  = c;
            2'd2:    t[63:32]  = c;
            default: t[31:0]   = c;
        endcase
        return t;
    endfunction

    // Row r rotates left by r columns.
    function automatic state_t shift_rows(input state_t s);
        state_t t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return t;
    endfunction

    // Row r rotates right by r columns.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/aes_shift_rows.sv
// Combinational ShiftRows / InvShiftRows; inverse selects the direction.
module aes_shift_rows
    import aes_round_pkg::*;
(
    input  logic         inverse,
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);

    // Pure byte permutation, no storage.
    always_comb begin
        state_o = inverse ? inv_shift_rows(state_i) : shift_rows(state_i);
    end

endmodule

// File: rtl/aes_column_round_sequencer.sv
// AES round stage: feeds one column per cycle to an external (Inv)MixColumns
// block and assembles the 128-bit result behind a valid/ready handshake.
module aes_column_round_sequencer
    import aes_round_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         in_inverse,
    input  logic         in_bypass,
    output logic [7:0]   mix_a,
    output logic [7:0]   mix_b,
    output logic [7:0]   mix_c,
    output logic [7:0]   mix_d,
    output logic         mix_control,
    input  logic [7:0]   mix_p,
    input  logic [7:0]   mix_q,
    input  logic [7:0]   mix_r,
    input  logic [7:0]   mix_s,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    seq_state_t             state_q, state_d;
    logic [COL_IDX_W-1:0]   col_idx_q, col_idx_d, col_nxt;
    state_t                 pre_q, pre_d;
    state_t                 key_q, key_d;
    state_t                 res_q, res_d;
    logic                   inv_q, inv_d;
    logic                   byp_q, byp_d;
    col_t                   mix_col_q, mix_col_d;
    logic                   mix_control_q, mix_control_d;
    logic                   out_valid_q, out_valid_d;
    state_t                 out_state_q, out_state_d;

    state_t                 pre_fwd, post_inv, pre_in, res_wr;
    col_t                   col_res;
    logic                   accept;

    aes_shift_rows u_pre_shift (
        .inverse (1'b0),
        .state_i (in_state),
        .state_o (pre_fwd)
    );

    aes_shift_rows u_post_shift (
        .inverse (1'b1),
        .state_i (res_wr),
        .state_o (post_inv)
    );

    // Ready while idle, or while the finished result is being taken this cycle.
    assign in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign col_nxt  = col_idx_q + COL_IDX_W'(1);

    // Pre-stage operand and the result with the current column written in.
    always_comb begin
        pre_in  = in_inverse ? (in_state ^ in_key) : pre_fwd;
        col_res = byp_q ? get_col(pre_q, col_idx_q) : col_t'({mix_p, mix_q, mix_r, mix_s});
        res_wr  = set_col(res_q, col_idx_q, col_res);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d       = state_q;
        col_idx_d     = col_idx_q;
        pre_d         = pre_q;
        key_d         = key_q;
        res_d         = res_q;
        inv_d         = inv_q;
        byp_d         = byp_q;
        mix_col_d     = mix_col_q;
        mix_control_d = mix_control_q;
        out_valid_d   = out_valid_q;
        out_state_d   = out_state_q;

        case (state_q)
            IDLE: begin
            end
            MIX: begin
                res_d = res_wr;
                if (col_idx_q == COL_IDX_W'(NUM_COLS - 1)) begin
                    state_d     = DONE;
                    col_idx_d   = '0;
                    out_valid_d = 1'b1;
                    out_state_d = inv_q ? post_inv : (res_wr ^ key_q);
                end else begin
                    col_idx_d = col_nxt;
                    mix_col_d = get_col(pre_q, col_nxt);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new state starts straight in MIX, also back-to-back from DONE.
        if (accept) begin
            state_d       = MIX;
            col_idx_d     = '0;
            pre_d         = pre_in;
            key_d         = in_key;
            inv_d         = in_inverse;
            byp_d         = in_bypass;
            mix_col_d     = get_col(pre_in, '0);
            mix_control_d = ~in_inverse;
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            col_idx_q     <= '0;
            pre_q         <= '0;
            key_q         <= '0;
            res_q         <= '0;
            inv_q         <= 1'b0;
            byp_q         <= 1'b0;
            mix_col_q     <= '0;
            mix_control_q <= 1'b1;
            out_valid_q   <= 1'b0;
            out_state_q   <= '0;
        end else begin
            state_q       <= state_d;
            col_idx_q     <= col_idx_d;
            pre_q         <= pre_d;
            key_q         <= key_d;
            res_q         <= res_d;
            inv_q         <= inv_d;
            byp_q         <= byp_d;
            mix_col_q     <= mix_col_d;
            mix_control_q <= mix_control_d;
            out_valid_q   <= out_valid_d;
            out_state_q   <= out_state_d;
        end
    end

    assign mix_a       = mix_col_q[3];
    assign mix_b       = mix_col_q[2];
    assign mix_c       = mix_col_q[1];
    assign mix_d       = mix_col_q[0];
    assign mix_control = mix_control_q;
    assign out_valid   = out_valid_q;
    assign out_state   = out_state_q;

endmodule
